// File: rtl/rr_mux_reg_if.sv
// -----------------------------------------------------------------------------
// rr_mux_reg_if
//
// This interface carries the bus signals of the rr_mux_reg N:1 channel
// selector. The clock and reset are not part of it.
//
//   mode      : 0 = direct select, 1 = round-robin arbitration
//   sel       : channel index used in direct mode
//   in_valid  : per-channel valid
//   in_data   : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  : per-channel ready (combinational)
//   out_valid : the output register holds data
//   out_data  : registered winner data
//   out_sel   : index of the channel that produced out_data
//   out_ready : the consumer accepts the output
//
// Modports:
//   master : producers/consumer side (drives the inputs, observes the outputs)
//   slave  : the rr_mux_reg block itself
// -----------------------------------------------------------------------------
interface rr_mux_reg_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = $clog2(N_IN)
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_IN-1:0]         in_valid;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic [N_IN-1:0]         in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_reg.sv
// -----------------------------------------------------------------------------
// rr_mux_reg
//
// This block selects one of N_IN valid/ready input channels and registers
// the winner into a single-entry output stage with a valid/ready handshake.
//   - Direct mode (mode=0): the external sel picks the channel. This behaves
//     like a plain N:1 mux followed by one register stage.
//   - Round-robin mode (mode=1): the block grants the first requesting
//     channel at or after rr_ptr, wrapping modulo N_IN. After each transfer,
//     rr_ptr moves to the channel just past the winner.
//
// The output stage reloads whenever it is empty or being drained in the
// same cycle. This allows one transfer per cycle with no bubbles.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : rr_mux_reg_if.slave (mode, sel, in_valid, in_data, in_ready,
//                out_valid, out_data, out_sel, out_ready)
//   clr_count  : synchronous clear of xfer_count   (RR_MUX_PERF_EN only)
//   xfer_count : saturating output-handshake count (RR_MUX_PERF_EN only)
//
// Optional feature:
//   When RR_MUX_PERF_EN is defined, the block adds the 16-bit xfer_count
//   output and the clr_count input. If the macro is undefined, neither
//   port exists and the block has no counter logic.
// -----------------------------------------------------------------------------
module rr_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux_reg_if.slave        bus
`ifdef RR_MUX_PERF_EN
  ,
  input  logic               clr_count,
  output logic [15:0]        xfer_count
`endif
);

  // The round-robin search indexes through a power-of-two padded copy of
  // in_valid. This keeps every index of SEL_W bits in range.
  localparam int NPAD = 1 << SEL_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [SEL_W-1:0]   out_sel_reg;
  logic [SEL_W-1:0]   rr_ptr_reg;

  // ---------------------------------------------------------------------------
  // Combinational grant path
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   ch_data [N_IN];
  logic [NPAD-1:0]    valid_pad;
  logic               load_en;
  logic               sel_in_range;
  logic               rr_found;
  logic [SEL_W-1:0]   rr_gnt;
  logic [SEL_W:0]     rr_cand;
  logic [SEL_W-1:0]   rr_ptr_next;
  logic [SEL_W-1:0]   gnt;
  logic               gnt_ok;
  logic [N_IN-1:0]    gnt_oh;
  logic [N_IN-1:0]    in_ready_int;
  logic [WIDTH-1:0]   gnt_data;
  logic               xfer;
  logic               out_hs;

  // The output stage can accept new data when it is empty, or when its
  // current entry leaves in this same cycle.
  assign load_en = !out_valid_reg || bus.out_ready;
  assign out_hs  = out_valid_reg && bus.out_ready;

  assign valid_pad = NPAD'(bus.in_valid);

  // In direct mode, a sel value at or above N_IN grants nothing. When N_IN
  // is a power of two, no such sel value exists.
  generate
    if (N_IN == (1 << SEL_W)) begin : g_sel_full
      assign sel_in_range = 1'b1;
    end else begin : g_sel_part
      assign sel_in_range = ({1'b0, bus.sel} < (SEL_W+1)'(N_IN));
    end
  endgenerate

  // Round-robin search: the first valid channel in the order rr_ptr,
  // rr_ptr+1, ..., wrapping at N_IN. The search uses one extra bit and
  // subtracts N_IN explicitly. This keeps the wrap correct for N_IN values
  // that are not a power of two.
  always_comb begin
    rr_found = 1'b0;
    rr_gnt   = '0;
    rr_cand  = '0;
    for (int k = 0; k < N_IN; k++) begin
      rr_cand = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
      if (rr_cand >= (SEL_W+1)'(N_IN)) begin
        rr_cand = rr_cand - (SEL_W+1)'(N_IN);
      end
      if (!rr_found && valid_pad[rr_cand[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_gnt   = rr_cand[SEL_W-1:0];
      end
    end
  end

  // The pointer advance past the winner, with an explicit wrap to zero.
  assign rr_ptr_next = (rr_gnt == SEL_W'(N_IN - 1)) ? '0 : rr_gnt + SEL_W'(1);

  // A mode change takes effect on the grant of the same cycle.
  assign gnt    = bus.mode ? rr_gnt   : bus.sel;
  assign gnt_ok = bus.mode ? rr_found : sel_in_range;

  // Per-channel slicing, one-hot grant and ready. In direct mode, ready
  // never looks at in_valid. In round-robin mode, in_valid reaches ready
  // only through the grant.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
      assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
      assign gnt_oh[gi]       = gnt_ok && (gnt == SEL_W'(gi));
      assign in_ready_int[gi] = load_en && gnt_oh[gi];
    end
  endgenerate

  assign bus.in_ready = in_ready_int;

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_oh[i]) begin
        gnt_data = gnt_data | ch_data[i];
      end
    end
  end

  assign xfer = |(bus.in_valid & in_ready_int);

  // ---------------------------------------------------------------------------
  // Output register and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= gnt_data;
        out_sel_reg   <= gnt;
      end else if (out_hs) begin
        // The entry drains. data and sel keep their last values.
        out_valid_reg <= 1'b0;
      end
      // The pointer moves only on round-robin transfers. Direct-mode
      // traffic leaves it where it was.
      if (xfer && bus.mode) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sel   = out_sel_reg;

`ifdef RR_MUX_PERF_EN
  // ---------------------------------------------------------------------------
  // Output handshake counter. It saturates at 16'hFFFF, and clear wins
  // over increment.
  // ---------------------------------------------------------------------------
  logic [15:0] xfer_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_reg <= '0;
    end else if (clr_count) begin
      xfer_count_reg <= '0;
    end else if (out_hs && (xfer_count_reg != 16'hFFFF)) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_reg
//
// This bench drives two instances of rr_mux_reg: A with N_IN=8 and B with
// N_IN=5. A behavioural model predicts in_ready and the output register of
// each instance from the select/arbitration rules. One compare process
// checks both instances on every falling edge. Directed sequences pin the
// model with literal expectations. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rr_mux_reg;
  localparam int W  = 32;
  localparam int NA = 8;
  localparam int NB = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_mux_reg_if #(.WIDTH(W), .N_IN(NA)) ifa ();
  rr_mux_reg_if #(.WIDTH(W), .N_IN(NB)) ifb ();

`ifdef RR_MUX_PERF_EN
  logic        clr_a = 1'b0;
  logic        clr_b = 1'b0;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  rr_mux_reg #(.WIDTH(W), .N_IN(NA)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifa)
`ifdef RR_MUX_PERF_EN
    ,
    .clr_count  (clr_a),
    .xfer_count (cnt_a)
`endif
  );

  rr_mux_reg #(.WIDTH(W), .N_IN(NB)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifb)
`ifdef RR_MUX_PERF_EN
    ,
    .clr_count  (clr_b),
    .xfer_count (cnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the contents of the output register plus the
  // arbitration pointer, one set per instance.
  // ---------------------------------------------------------------------------
  bit          m_v    [2] = '{0, 0};
  logic [31:0] m_data [2] = '{0, 0};
  int          m_sel  [2] = '{0, 0};
  int          m_ptr  [2] = '{0, 0};
  int          m_cnt  [2] = '{0, 0};

  initial begin : compare
    bit          nx_v    [2];
    logic [31:0] nx_data [2];
    int          nx_sel  [2];
    int          nx_ptr  [2];
    int          nx_cnt  [2];
    bit          commit;
    int          n, s, g, os, oc, c;
    bit          md, ordy, clr, ov, ok, load_en, xfer, hs;
    logic [15:0] v, rdy, exp_rdy;
    logic [31:0] od;
    logic [31:0] dat [16];
    string       tag;
    forever begin
      @(negedge clk);
      commit = 1'b0;
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          m_v[d] = 0; m_data[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
        end
      end
      for (int d = 0; d < 2; d++) begin
        clr = 1'b0; oc = 0;
        for (int i = 0; i < 16; i++) dat[i] = '0;
        if (d == 0) begin
          tag = "A"; n = NA; md = ifa.mode; s = int'(ifa.sel);
          v = 16'(ifa.in_valid); rdy = 16'(ifa.in_ready); ordy = ifa.out_ready;
          for (int i = 0; i < NA; i++) dat[i] = ifa.in_data[i*W +: W];
          ov = ifa.out_valid; od = ifa.out_data; os = int'(ifa.out_sel);
`ifdef RR_MUX_PERF_EN
          clr = clr_a; oc = int'(cnt_a);
`endif
        end else begin
          tag = "B"; n = NB; md = ifb.mode; s = int'(ifb.sel);
          v = 16'(ifb.in_valid); rdy = 16'(ifb.in_ready); ordy = ifb.out_ready;
          for (int i = 0; i < NB; i++) dat[i] = ifb.in_data[i*W +: W];
          ov = ifb.out_valid; od = ifb.out_data; os = int'(ifb.out_sel);
`ifdef RR_MUX_PERF_EN
          clr = clr_b; oc = int'(cnt_b);
`endif
        end

        chk({tag, " out_valid"}, 32'(ov), 32'(m_v[d]));
        chk({tag, " out_data"},  od,      m_data[d]);
        chk({tag, " out_sel"},   32'(os), 32'(m_sel[d]));
`ifdef RR_MUX_PERF_EN
        chk({tag, " xfer_count"}, 32'(oc), 32'(m_cnt[d]));
`endif

        if (rst_n) begin
          // The grant follows the rules: sel in direct mode, or the first
          // valid channel at or after the pointer, modulo n.
          ok = 1'b0; g = 0;
          if (!md) begin
            ok = (s < n); g = s;
          end else begin
            for (int k = 0; k < n; k++) begin
              c = (m_ptr[d] + k) % n;
              if (!ok && v[c]) begin ok = 1'b1; g = c; end
            end
          end
          load_en = !m_v[d] || ordy;
          exp_rdy = (ok && load_en) ? (16'd1 << g) : 16'd0;
          chk({tag, " in_ready"}, 32'(rdy), 32'(exp_rdy));

          xfer = ok && load_en && v[g];
          hs   = m_v[d] && ordy;
          nx_v[d] = m_v[d]; nx_data[d] = m_data[d]; nx_sel[d] = m_sel[d];
          if (xfer) begin
            nx_v[d] = 1'b1; nx_data[d] = dat[g]; nx_sel[d] = g;
          end else if (hs) begin
            nx_v[d] = 1'b0;
          end
          nx_ptr[d] = (xfer && md) ? (g + 1) % n : m_ptr[d];
          nx_cnt[d] = clr ? 0 : ((hs && m_cnt[d] < 65535) ? m_cnt[d] + 1 : m_cnt[d]);
          commit = 1'b1;
        end
      end
      @(posedge clk);
      if (commit && rst_n) begin
        for (int d = 0; d < 2; d++) begin
          m_v[d] = nx_v[d]; m_data[d] = nx_data[d]; m_sel[d] = nx_sel[d];
          m_ptr[d] = nx_ptr[d]; m_cnt[d] = nx_cnt[d];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive();
    ifa.mode      = ($urandom_range(0, 3) != 0);
    ifa.sel       = 3'($urandom_range(0, 7));
    ifa.in_valid  = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
    ifa.out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NA; i++) ifa.in_data[i*W +: W] = $urandom;
    ifb.mode      = ($urandom_range(0, 3) != 0);
    ifb.sel       = 3'($urandom_range(0, 7));
    ifb.in_valid  = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'($urandom & $urandom);
    ifb.out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NB; i++) ifb.in_data[i*W +: W] = $urandom;
`ifdef RR_MUX_PERF_EN
    clr_a = ($urandom_range(0, 15) == 0);
    clr_b = ($urandom_range(0, 15) == 0);
`endif
  endtask

  initial begin : stim
    ifa.mode = 1'b0; ifa.sel = '0; ifa.in_valid = '0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.mode = 1'b0; ifb.sel = '0; ifb.in_valid = '0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    repeat (3) cyc();
    chk("A reset out_valid", 32'(ifa.out_valid), 32'd0);
    chk("A reset out_sel",   32'(ifa.out_sel),   32'd0);

    // Reset is released, then direct mode runs with sel=5.
    rst_n = 1'b1;
    ifa.mode = 1'b0; ifa.sel = 3'd5; ifa.in_valid = '1; ifa.out_ready = 1'b1;
    for (int i = 0; i < NA; i++) ifa.in_data[i*W +: W] = 32'h100 + i;
    #1;
    chk("A direct in_ready", 32'(ifa.in_ready), 32'h20);
    cyc();
    chk("A direct out_data",  ifa.out_data,       32'h105);
    chk("A direct out_sel",   32'(ifa.out_sel),   32'd5);
    chk("A direct out_valid", 32'(ifa.out_valid), 32'd1);

    // Round-robin fairness: the pointer is still 0 after direct traffic.
    ifa.mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("A rr out_sel",   32'(ifa.out_sel),   32'(k % 8));
      chk("A rr out_data",  ifa.out_data,       32'h100 + 32'(k % 8));
      chk("A rr out_valid", 32'(ifa.out_valid), 32'd1);
    end

    // A single grant to channel 1 moves the pointer to 2. The sparse
    // pattern then wraps 7, 1, 7, 1.
    ifa.in_valid = 8'b0000_0010;
    cyc();
    chk("A ptr-setup out_sel", 32'(ifa.out_sel), 32'd1);
    ifa.in_valid = 8'b1000_0010;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("A sparse out_sel", 32'(ifa.out_sel), (k % 2 == 0) ? 32'd7 : 32'd1);
    end

    // Backpressure: the last entry was channel 1 and the pointer is 2.
    ifa.in_valid = '1; ifa.out_ready = 1'b0;
    #1;
    chk("A bp in_ready", 32'(ifa.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("A bp out_data", ifa.out_data,       32'h101);
      chk("A bp in_ready", 32'(ifa.in_ready),  32'd0);
    end
    ifa.out_ready = 1'b1;
    #1;
    chk("A refill in_ready", 32'(ifa.in_ready), 32'h04);
    cyc();
    chk("A refill out_valid", 32'(ifa.out_valid), 32'd1);
    chk("A refill out_sel",   32'(ifa.out_sel),   32'd2);

    // Reset arrives mid-stream while an entry is held.
    rst_n = 1'b0;
    #1;
    chk("A async rst out_valid", 32'(ifa.out_valid), 32'd0);
    chk("A async rst out_data",  ifa.out_data,       32'd0);
    chk("A async rst out_sel",   32'(ifa.out_sel),   32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("A post-rst first grant", 32'(ifa.out_sel), 32'd0);

    // N_IN=5 round-robin: the sequence is 0..4,0, with the counter and a
    // clear that collides with a handshake.
    ifb.mode = 1'b1; ifb.in_valid = '1; ifb.out_ready = 1'b1;
    for (int i = 0; i < NB; i++) ifb.in_data[i*W +: W] = 32'h200 + i;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k < 6) chk("B rr5 out_sel", 32'(ifb.out_sel), 32'(k % 5));
    end
`ifdef RR_MUX_PERF_EN
    chk("B xfer_count after 6", 32'(cnt_b), 32'd6);
    clr_b = 1'b1;
    cyc();
    clr_b = 1'b0;
    chk("B xfer_count cleared", 32'(cnt_b), 32'd0);
`endif

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 600; k++) begin
      rand_drive();
      cyc();
    end
    ifa.in_valid = '0; ifb.in_valid = '0; ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
`ifdef RR_MUX_PERF_EN
    clr_a = 1'b0; clr_b = 1'b0;
`endif
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
